// File: rtl/uart_rx_sync_if.sv
// Serial receive bundle: raw RX line in, byte/strobe/status out.
// The receiver uses master; the consumer/line driver uses slave.
interface uart_rx_sync_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        input  rx,
        output rx_data,
        output rx_valid,
        output frame_err,
        output rx_busy
    );

    modport slave (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit start check,
// centre sampling LSB first, one-cycle byte strobe and framing error.
module uart_rx_sync #(
    parameter logic [9:0] BPS_CNT = 10'd434
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_sync_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam logic [9:0] HALF_M1 = (BPS_CNT >> 1) - 10'd1;
    localparam logic [9:0] FULL_M1 = BPS_CNT - 10'd1;

    state_t     state, state_n;
    logic       rx_m, rx_s;
    logic [9:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] sh, sh_n;
    logic [7:0] data_q, data_n;
    logic       valid_q, valid_n;
    logic       ferr_q, ferr_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            sh      <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            rx_m    <= bus.rx;
            rx_s    <= rx_m;
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            sh      <= sh_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            ferr_q  <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 10'd1;
        idx_n   = idx;
        sh_n    = sh;
        data_n  = data_q;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    // High at mid start bit means it was only a glitch
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_n = '0;
                    sh_n  = {rx_s, sh[7:1]};
                    idx_n = idx + 3'd1;
                    if (idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_n  = sh;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.rx_busy   = (state != IDLE);

endmodule
